wbuf: RTL and testbench

WBUF -- requirements
Module: wbuf

---
 rtl/wbuf_if.sv | 32 +++
 rtl/wbuf.sv | 97 +++++++++
 tb/tb_wbuf.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/wbuf_if.sv
// Store-side, drain-side and line-conflict signals of the write buffer.
// The master side is the data cache / arbiter; wbuf attaches on the slave side.
interface wbuf_if #(
  parameter int CMEM_OFFS_LEN = 6,
  parameter int CMEM_BLK_LEN  = 64 - CMEM_OFFS_LEN
);
  logic [63:0]             s_addr;
  logic [63:0]             s_wdata;
  logic [1:0]              s_len;
  logic                    s_wr;
  logic                    s_ready;
  logic [63:0]             b_addr_w;
  logic [63:0]             b_wdata_w;
  logic [1:0]              b_len_w;
  logic                    b_wr_w;
  logic                    w_ack;
  logic [CMEM_BLK_LEN-1:0] r_addr;
  logic                    r_conflict;
  logic                    w_empty;

  // Handshake: a store transfers on a rising edge where s_wr && s_ready;
  // the head entry retires on a rising edge where b_wr_w && w_ack.
  modport master (
    output s_addr, s_wdata, s_len, s_wr, w_ack, r_addr,
    input  s_ready, b_addr_w, b_wdata_w, b_len_w, b_wr_w, r_conflict, w_empty
  );

  modport slave (
    input  s_addr, s_wdata, s_len, s_wr, w_ack, r_addr,
    output s_ready, b_addr_w, b_wdata_w, b_len_w, b_wr_w, r_conflict, w_empty
  );
endinterface

// File: rtl/wbuf.sv
// Store write buffer: DEPTH-entry circular FIFO between data cache and write arbiter.
// Optional store coalescing into the youngest entry is enabled by defining WBUF_COALESCE_EN.
module wbuf #(
  parameter int  DEPTH         = 4,
  parameter int  CMEM_OFFS_LEN = 6,
  localparam int PTR_W         = $clog2(DEPTH),
  localparam int CNT_W         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  wbuf_if.slave            bus,
  output logic [CNT_W-1:0] dbg_count_o
);

  logic [63:0]      addr_q [DEPTH];
  logic [63:0]      data_q [DEPTH];
  logic [1:0]       len_q  [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, match, push, pop, conflict;
  logic [PTR_W-1:0] off;

`ifdef WBUF_COALESCE_EN
  logic [PTR_W-1:0] young;
  assign young = wr_ptr_q - PTR_W'(1);
  // Only merge when the youngest entry is not the head, so the in-flight write stays stable.
  assign match = (count_q >= CNT_W'(2)) && (addr_q[young] == bus.s_addr) &&
                 (len_q[young] == bus.s_len);
`else
  assign match = 1'b0;
`endif

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.s_wr && bus.s_ready && !match;
  assign pop   = bus.w_ack && !empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload is never reset; validity is carried solely by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.s_addr;
      data_q[wr_ptr_q] <= bus.s_wdata;
      len_q[wr_ptr_q]  <= bus.s_len;
    end
`ifdef WBUF_COALESCE_EN
    else if (bus.s_wr && match) begin
      data_q[young] <= bus.s_wdata;
    end
`endif
  end

  always_comb begin
    off      = '0;
    conflict = bus.s_wr && (bus.s_addr[63:CMEM_OFFS_LEN] == bus.r_addr);
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && (addr_q[i][63:CMEM_OFFS_LEN] == bus.r_addr))
        conflict = 1'b1;
    end
  end

  assign bus.s_ready    = !full || match;
  assign bus.b_wr_w     = !empty;
  assign bus.b_addr_w   = addr_q[rd_ptr_q];
  assign bus.b_wdata_w  = data_q[rd_ptr_q];
  assign bus.b_len_w    = len_q[rd_ptr_q];
  assign bus.r_conflict = conflict;
  assign bus.w_empty    = empty;
  assign dbg_count_o    = count_q;

endmodule

// File: tb/tb_wbuf.sv
// Bench for wbuf (DEPTH=4, 64-byte lines): queue-based reference of buffered stores,
// checked every cycle on handshake, head entry, count and line conflict.
module tb_wbuf;
  localparam int DEPTH = 4;
  localparam int OFFS  = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_count;

  always #5 clk = ~clk;

  wbuf_if #(.CMEM_OFFS_LEN(OFFS)) bus ();

  wbuf #(.DEPTH(DEPTH), .CMEM_OFFS_LEN(OFFS)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_count_o (dbg_count)
  );

  // Entry packing: {addr[63:0], data[63:0], len[1:0]}
  logic [129:0] exp_q[$];
  int           n_cmp   = 0;
  int           n_bad   = 0;
  int           m_count = 0;
  bit           coal_en;

  task automatic check(input string tag, input logic [129:0] act, input logic [129:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic exp_conflict(input bit do_wr, input logic [63:0] addr);
    logic [129:0] e;
    logic         c;
    c = do_wr && (addr[63:OFFS] == bus.r_addr);
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      if (e[129:66+OFFS] == bus.r_addr) c = 1'b1;
    end
    return c;
  endfunction

  // One clock cycle: drive, check combinational outputs against the model, clock, update model.
  task automatic step(input bit do_wr, input logic [63:0] addr, input logic [63:0] data,
                      input logic [1:0] len, input bit do_ack);
    logic [129:0] young;
    logic [129:0] head;
    bit           match;
    bit           accept;
    bus.s_wr    = do_wr;
    bus.s_addr  = addr;
    bus.s_wdata = data;
    bus.s_len   = len;
    bus.w_ack   = do_ack;
    #1;
    match = 1'b0;
    if (coal_en && m_count >= 2) begin
      young = exp_q[exp_q.size()-1];
      match = (young[129:66] == addr) && (young[1:0] == len);
    end
    accept = do_wr && (m_count != DEPTH || match);
    check("s_ready", bus.s_ready, (m_count != DEPTH) || match);
    check("b_wr_w", bus.b_wr_w, m_count != 0);
    check("w_empty", bus.w_empty, m_count == 0);
    check("count", dbg_count, m_count);
    check("r_conflict", bus.r_conflict, exp_conflict(do_wr, addr));
    if (m_count != 0) begin
      head = exp_q[0];
      check("head", {bus.b_addr_w, bus.b_wdata_w, bus.b_len_w}, head);
    end
    @(posedge clk);
    #1;
    bus.s_wr  = 1'b0;
    bus.w_ack = 1'b0;
    if (do_ack && m_count != 0) begin
      void'(exp_q.pop_front());
      m_count--;
    end
    if (accept) begin
      if (match) begin
        young = exp_q[exp_q.size()-1];
        young[65:2] = data;
        exp_q[exp_q.size()-1] = young;
      end else begin
        exp_q.push_back({addr, data, len});
        m_count++;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 64'h0, 64'h0, 2'b00, 1'b0);
  endtask

  task automatic do_reset(input bit with_ack);
    rst       = 1'b1;
    bus.s_wr  = 1'b0;
    bus.w_ack = with_ack;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.w_ack = 1'b0;
    exp_q.delete();
    m_count   = 0;
  endtask

  logic [63:0] ra;

  initial begin
`ifdef WBUF_COALESCE_EN
    coal_en = 1'b1;
`else
    coal_en = 1'b0;
`endif
    rst         = 1'b1;
    bus.s_wr    = 1'b0;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    bus.s_len   = '0;
    bus.w_ack   = 1'b0;
    bus.r_addr  = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);

    // Reset state
    idle();

    // Single store, then retire it
    step(1'b1, 64'h8000_0010, 64'h11, 2'b00, 1'b0);
    #1;
    check("t1_wr", bus.b_wr_w, 1'b1);
    check("t1_addr", bus.b_addr_w, 64'h8000_0010);
    check("t1_len", bus.b_len_w, 2'b00);
    step(1'b0, 64'h0, 64'h0, 2'b00, 1'b1);
    #1;
    check("t1_drained", bus.b_wr_w, 1'b0);
    check("t1_empty", bus.w_empty, 1'b1);

    // Overfill: fifth store dropped, drain wraps both pointers
    for (int i = 0; i < 5; i++)
      step(1'b1, 64'h8000_1000 + 64'(i * 8), 64'hA0 + 64'(i), 2'b11, 1'b0);
    #1;
    check("full_ready", bus.s_ready, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 64'h0, 64'h0, 2'b00, 1'b1);
    step(1'b0, 64'h0, 64'h0, 2'b00, 1'b1);
    idle();

    // Push and pop in the same cycle with two entries held
    step(1'b1, 64'h8000_2000, 64'h1, 2'b10, 1'b0);
    step(1'b1, 64'h8000_2010, 64'h2, 2'b10, 1'b0);
    step(1'b1, 64'h8000_2020, 64'h3, 2'b10, 1'b1);
    #1;
    check("pp_count", dbg_count, 3'd2);
    check("pp_head", bus.b_addr_w, 64'h8000_2010);
    step(1'b0, 64'h0, 64'h0, 2'b00, 1'b1);
    #1;
    check("pp_third", bus.b_addr_w, 64'h8000_2020);
    step(1'b0, 64'h0, 64'h0, 2'b00, 1'b1);

    // Line conflict against a buffered and an incoming store
    ra = 64'h8000_0040 >> OFFS;
    bus.r_addr = ra[57:0];
    step(1'b1, 64'h8000_0040, 64'h55, 2'b10, 1'b0);
    #1;
    check("cf_hit", bus.r_conflict, 1'b1);
    ra = 64'h8000_0080 >> OFFS;
    bus.r_addr = ra[57:0];
    #1;
    check("cf_miss", bus.r_conflict, 1'b0);
    ra = 64'h8000_0040 >> OFFS;
    bus.r_addr = ra[57:0];
    step(1'b0, 64'h0, 64'h0, 2'b00, 1'b1);
    #1;
    check("cf_after_ack", bus.r_conflict, 1'b0);
    step(1'b1, 64'h8000_0048, 64'h66, 2'b00, 1'b1);
    step(1'b0, 64'h0, 64'h0, 2'b00, 1'b1);

    // Coalescing into the youngest entry
    step(1'b1, 64'h100, 64'hAAAA, 2'b11, 1'b0);
    step(1'b1, 64'h108, 64'hBBBB, 2'b11, 1'b0);
    step(1'b1, 64'h108, 64'hBEEF, 2'b11, 1'b0);
    #1;
    check("co_count", dbg_count, coal_en ? 3'd2 : 3'd3);
    step(1'b0, 64'h0, 64'h0, 2'b00, 1'b1);
    #1;
    check("co_data", bus.b_wdata_w, coal_en ? 64'hBEEF : 64'hBBBB);
    for (int i = 0; i < 3 && m_count > 0; i++) step(1'b0, 64'h0, 64'h0, 2'b00, 1'b1);

    // Reset with an unacknowledged head and ack in the reset cycle
    for (int i = 0; i < 3; i++) step(1'b1, 64'h8000_3000 + 64'(i * 8), 64'(i), 2'b11, 1'b0);
    do_reset(1'b1);
    #1;
    check("rst_wr", bus.b_wr_w, 1'b0);
    check("rst_empty", bus.w_empty, 1'b1);
    step(1'b0, 64'h0, 64'h0, 2'b00, 1'b1);
    idle();

    // Random traffic over a few addresses
    for (int i = 0; i < 80; i++) begin
      logic [63:0] a;
      a = 64'h8000_0000 + 64'($urandom_range(0, 3) * 8) + 64'($urandom_range(0, 1) * 64);
      ra = (64'h8000_0000 + 64'($urandom_range(0, 1) * 64)) >> OFFS;
      bus.r_addr = ra[57:0];
      step(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 64'h0, 64'h0, 2'b00, 1'b1);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
